// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter_pkg
// Description : Shared types and constants for the two-master memory arbiter.
//               FSM state encoding, master index constants and data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_arbiter_pkg;

    // Arbiter FSM states (2-bit encoding, registered in memory_arbiter)
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    // Master index constants, also used as the grant encoding
    localparam logic c_ARB_M0 = 1'b0;
    localparam logic c_ARB_M1 = 1'b1;

    // Memory data path widths
    localparam int c_DATA_W = 32;
    localparam int c_STRB_W = 4;

endpackage : memory_arbiter_pkg
`default_nettype wire

// File: rtl/memory_arbiter_rr2.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_rr2
// Description : Combinational two-requester grant selection.
//               Default: round-robin, the master that did not win last gets
//               the tie. With MUSB_ARB_FIXED_PRIO_EN defined, master 0 always
//               wins a tie and last_grant is ignored.
// Ports       : req0, req1   - request lines of master 0 / master 1
//               last_grant   - index of the most recently served master
//               grant        - index of the selected master
//               valid        - at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_rr2
    import memory_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    assign valid = req0 | req1;

`ifdef MUSB_ARB_FIXED_PRIO_EN
    // History is irrelevant under fixed priority; tie it off explicitly.
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;

    always_comb begin
        grant = req0 ? c_ARB_M0 : (req1 ? c_ARB_M1 : c_ARB_M0);
    end
`else
    always_comb begin
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = c_ARB_M1;
        end else begin
            grant = c_ARB_M0;
        end
    end
`endif

endmodule : arbiter_rr2
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Two-master arbiter for one port of a dual-port memory.
//               Registers the winning request onto mem_*, pulses mem_enable
//               for one cycle, then forwards mem_dout/mem_ready to the granted
//               master only. Round-robin by default; fixed priority (master 0
//               wins) when MUSB_ARB_FIXED_PRIO_EN is defined.
// Ports       : clk, rst_n             - clock, async active-low reset
//               m0_* / m1_*            - master request/response channels
//               mem_*                  - memory port (registered request side)
//               busy                   - transfer in flight (ISSUE or WAIT)
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // master 0
    input  logic [ADDR_SIZE-1:0] m0_addr,
    input  logic [c_DATA_W-1:0]  m0_din,
    input  logic [c_STRB_W-1:0]  m0_wr,
    input  logic                 m0_enable,
    output logic [c_DATA_W-1:0]  m0_dout,
    output logic                 m0_ready,
    // master 1
    input  logic [ADDR_SIZE-1:0] m1_addr,
    input  logic [c_DATA_W-1:0]  m1_din,
    input  logic [c_STRB_W-1:0]  m1_wr,
    input  logic                 m1_enable,
    output logic [c_DATA_W-1:0]  m1_dout,
    output logic                 m1_ready,
    // memory port
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [c_DATA_W-1:0]  mem_din,
    output logic [c_STRB_W-1:0]  mem_wr,
    output logic                 mem_enable,
    input  logic [c_DATA_W-1:0]  mem_dout,
    input  logic                 mem_ready,
    // status
    output logic                 busy
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_gnt;
    logic       r_last_grant;
    logic       w_sample;
    logic       w_done;
    logic       w_issue;
    logic       w_arb_last;
    logic       w_arb_grant;
    logic       w_arb_valid;

    // On the completion cycle the finishing master counts as the last grant,
    // so the immediate re-arbitration already sees the updated history.
    assign w_arb_last = (r_state == ARB_WAIT) ? r_gnt : r_last_grant;

    arbiter_rr2 u_arbiter_rr2 (
        .req0       (m0_enable),
        .req1       (m1_enable),
        .last_grant (w_arb_last),
        .grant      (w_arb_grant),
        .valid      (w_arb_valid)
    );

    // Next-state logic: requests are only looked at in IDLE and on the
    // completion cycle of WAIT.
    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                w_sample = 1'b1;
                if (w_arb_valid) begin
                    w_next_state = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                w_next_state = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (mem_ready) begin
                    w_done       = 1'b1;
                    w_sample     = 1'b1;
                    w_next_state = w_arb_valid ? ARB_ISSUE : ARB_IDLE;
                end
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    assign w_issue = w_sample & w_arb_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_gnt        <= c_ARB_M0;
            r_last_grant <= c_ARB_M1;   // master 0 wins the first tie
            mem_addr     <= '0;
            mem_din      <= '0;
            mem_wr       <= '0;
            mem_enable   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            mem_enable <= w_issue;
            if (w_issue) begin
                r_gnt    <= w_arb_grant;
                mem_addr <= (w_arb_grant == c_ARB_M1) ? m1_addr : m0_addr;
                mem_din  <= (w_arb_grant == c_ARB_M1) ? m1_din  : m0_din;
                mem_wr   <= (w_arb_grant == c_ARB_M1) ? m1_wr   : m0_wr;
            end
            if (w_done) begin
                r_last_grant <= r_gnt;
            end
        end
    end

    // Return path: ready/data reach the granted master only, and data is
    // gated by ready so the memory's high-Z never leaks out.
    assign m0_ready = w_done & (r_gnt == c_ARB_M0);
    assign m1_ready = w_done & (r_gnt == c_ARB_M1);
    assign m0_dout  = m0_ready ? mem_dout : '0;
    assign m1_dout  = m1_ready ? mem_dout : '0;

    assign busy = (r_state != ARB_IDLE);

endmodule : memory_arbiter
`default_nettype wire
